// File: rtl/ws_array_pkg.sv
// Shared types and default widths for the weight-stationary array sequencer.
//   ws_state_t : sequencer states (IDLE, LOAD_WT, STREAM, DRAIN)
//   BIT_WIDTH  : activation / weight element width
//   ACC_WIDTH  : accumulator lane width
//   ARR_SIZE   : array rows / columns
package ws_array_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_WT = 2'd1,
        STREAM  = 2'd2,
        DRAIN   = 2'd3
    } ws_state_t;

    localparam int BIT_WIDTH = 8;
    localparam int ACC_WIDTH = 32;
    localparam int ARR_SIZE  = 4;

endpackage

// File: rtl/ws_array_ctrl_lane_delay.sv
// lane_delay: fixed-length register chain for one data lane.
// Used for the input skew in front of the array and the output deskew
// behind it. A depth of 0 degenerates to a plain wire.
// Ports:
//   clk   in   1      clock, rising edge
//   rst   in   1      synchronous active-high reset, clears every stage
//   din   in   WIDTH  lane input
//   dout  out  WIDTH  lane input delayed by DEPTH cycles
module lane_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_chain
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        stage[k] <= '0;
                    end
                end else begin
                    stage[0] <= din;
                    for (int k = 1; k < DEPTH; k++) begin
                        stage[k] <= stage[k-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/ws_array_ctrl.sv
// ws_array_ctrl: sequencer for a weight-stationary systolic array.
// Loads a weight tile row by row, streams activation vectors with the
// per-lane input skew the array needs, and deskews the accumulator lanes
// into aligned result vectors with a valid strobe.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// LOAD_WT  | arr_control=1, accepting `size` weight rows
// STREAM   | arr_control=0, accepting `num_vec` activation vectors
// DRAIN    | injecting zeros until the last tagged result is emitted
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a job (IDLE only)
//   busy, done          not-IDLE flag, one-cycle completion pulse
//   wt_valid/ready/data weight row handshake
//   act_valid/ready/data activation vector handshake
//   arr_control         array mode, 1 = weight load
//   arr_wt, arr_data    array weight row and skewed activation inputs
//   arr_acc             array accumulator lanes
//   res_valid, res_data aligned result vector
module ws_array_ctrl
    import ws_array_pkg::*;
#(
    parameter int depth     = ARR_SIZE,
    parameter int bit_width = BIT_WIDTH,
    parameter int acc_width = ACC_WIDTH,
    parameter int size      = ARR_SIZE,
    parameter int num_vec   = 4,
    parameter int arr_lat   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    input  logic                        wt_valid,
    output logic                        wt_ready,
    input  logic [bit_width*depth-1:0]  wt_data,
    input  logic                        act_valid,
    output logic                        act_ready,
    input  logic [bit_width*depth-1:0]  act_data,
    output logic                        arr_control,
    output logic [bit_width*depth-1:0]  arr_wt,
    output logic [bit_width*depth-1:0]  arr_data,
    input  logic [acc_width*size-1:0]   arr_acc,
    output logic                        res_valid,
    output logic [acc_width*size-1:0]   res_data
);

    localparam int WT_CW   = $clog2(size + 1);
    // A tag entering with the vector reaches the output after the array
    // latency plus the widest deskew.
    localparam int TAG_LEN = arr_lat + size - 1;

    ws_state_t state;
    ws_state_t state_next;

    logic [WT_CW-1:0]           wt_cnt;
    logic [7:0]                 vec_cnt;
    logic                       wt_hs;
    logic                       act_hs;
    logic                       wt_last;
    logic                       act_last;
    logic                       tags_pending;

    logic [bit_width*depth-1:0] act_q;
    logic                       tag_q;
    logic [TAG_LEN-1:0]         tag_sr;
    logic [acc_width*size-1:0]  deskewed;

    assign wt_hs        = wt_valid & wt_ready;
    assign act_hs       = act_valid & act_ready;
    assign wt_last      = (wt_cnt == WT_CW'(size - 1));
    assign act_last     = (vec_cnt == 8'(num_vec - 1));
    assign res_valid    = tag_sr[TAG_LEN-1];
    // Any tagged vector still upstream of the output stage.
    assign tags_pending = tag_q | (|tag_sr[TAG_LEN-2:0]);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wt_ready   = 1'b0;
        act_ready  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD_WT;
                end
            end
            LOAD_WT: begin
                wt_ready = 1'b1;
                if (wt_valid && wt_last) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                act_ready = 1'b1;
                if (act_valid && act_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // The beat on the output now is the last tagged one.
                if (res_valid && !tags_pending) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wt_cnt      <= '0;
            vec_cnt     <= '0;
            arr_control <= 1'b0;
            arr_wt      <= '0;
            act_q       <= '0;
            tag_q       <= 1'b0;
            tag_sr      <= '0;
        end else begin
            // Registered from the next state so the first STREAM cycle
            // already drives compute mode.
            arr_control <= (state_next == LOAD_WT);

            if (state == IDLE && start) begin
                wt_cnt  <= '0;
                vec_cnt <= '0;
            end

            if (wt_hs) begin
                arr_wt <= wt_data;
                wt_cnt <= wt_cnt + 1'b1;
            end

            if (act_hs) begin
                vec_cnt <= vec_cnt + 1'b1;
            end

            // Cycles without an accepted vector inject an untagged bubble.
            act_q  <= act_hs ? act_data : '0;
            tag_q  <= act_hs;
            tag_sr <= {tag_sr[TAG_LEN-2:0], tag_q};
        end
    end

    // Input skew: lane i reaches the array i cycles after lane 0.
    for (genvar i = 0; i < depth; i++) begin : g_skew
        lane_delay #(
            .WIDTH (bit_width),
            .DEPTH (i)
        ) u_skew (
            .clk  (clk),
            .rst  (rst),
            .din  (act_q[i*bit_width +: bit_width]),
            .dout (arr_data[i*bit_width +: bit_width])
        );
    end

    // Output deskew: column c finishes c cycles after column 0, so it is
    // held back size-1-c cycles to line all columns up.
    for (genvar c = 0; c < size; c++) begin : g_deskew
        lane_delay #(
            .WIDTH (acc_width),
            .DEPTH (size - 1 - c)
        ) u_deskew (
            .clk  (clk),
            .rst  (rst),
            .din  (arr_acc[c*acc_width +: acc_width]),
            .dout (deskewed[c*acc_width +: acc_width])
        );
    end

    // The last column has no deskew register, so its lane would follow the
    // array combinationally; gating keeps the result bus quiet between beats
    // and zero while in reset.
    assign res_data = res_valid ? deskewed : '0;

endmodule

// File: tb/tb_ws_array_ctrl.sv
module tb_ws_array_ctrl;

    localparam int NV      = 4;
    localparam int ARR_LAT = 2;
    localparam int P_IDLE   = 0;
    localparam int P_LOAD   = 1;
    localparam int P_STREAM = 2;
    localparam int P_DRAIN  = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         busy;
    logic         done;
    logic         wt_valid;
    logic         wt_ready;
    logic [31:0]  wt_data;
    logic         act_valid;
    logic         act_ready;
    logic [31:0]  act_data;
    logic         arr_control;
    logic [31:0]  arr_wt;
    logic [31:0]  arr_data;
    logic [127:0] arr_acc = '0;
    logic         res_valid;
    logic [127:0] res_data;

    ws_array_ctrl #(
        .depth     (4),
        .bit_width (8),
        .acc_width (32),
        .size      (4),
        .num_vec   (NV),
        .arr_lat   (ARR_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .wt_valid    (wt_valid),
        .wt_ready    (wt_ready),
        .wt_data     (wt_data),
        .act_valid   (act_valid),
        .act_ready   (act_ready),
        .act_data    (act_data),
        .arr_control (arr_control),
        .arr_wt      (arr_wt),
        .arr_data    (arr_data),
        .arr_acc     (arr_acc),
        .res_valid   (res_valid),
        .res_data    (res_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out @cyc %0d", name, cyc);
    endtask

    // ---------------- reference model ----------------
    // vec0[T]/tag0[T]: vector entering array lane 0 in cycle T (accepted at T-1).
    bit [31:0] vec0 [64];
    bit        tag0 [64];
    bit [31:0] w_rows [4];
    int        kill_cyc = 0;
    int        phase = P_IDLE;
    int        wcnt = 0;
    int        vcnt = 0;
    int        rcnt = 0;
    bit [31:0] exp_wt = '0;

    function automatic int idx(input int x);
        return x & 63;
    endfunction

    // Array result for vector v: lane c = sum over rows r of w[r][c] * v[r].
    function automatic logic [127:0] mat_vec(input bit [31:0] v);
        logic [127:0] r;
        int unsigned  sum;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            sum = 0;
            for (int k = 0; k < 4; k++) begin
                sum += 32'(w_rows[k][8*c +: 8]) * 32'(v[8*k +: 8]);
            end
            r[32*c +: 32] = sum;
        end
        return r;
    endfunction

    function automatic bit [31:0] vec_at(input int t);
        if (t < 0 || t < kill_cyc) return '0;
        return vec0[idx(t)];
    endfunction

    // Behavioural array: column c of the vector entering lane 0 at T
    // appears on acc_out at T + ARR_LAT + c.
    always @(posedge clk) begin
        logic [127:0] full;
        #1;
        for (int c = 0; c < 4; c++) begin
            full = mat_vec(vec_at(cyc - ARR_LAT - c));
            arr_acc[32*c +: 32] = full[32*c +: 32];
        end
    end

    // Observation counters for the directed literal checks.
    int           beats = 0;
    int           first_res = -1;
    int           first_acc = -1;
    int           done_beats = -1;
    logic [127:0] res_log [$];

    task automatic clear_obs();
        beats = 0;
        first_res = -1;
        first_acc = -1;
        done_beats = -1;
        res_log.delete();
    endtask

    always @(negedge clk) begin
        logic [127:0] e_res;
        logic [31:0]  e_ad;
        logic [31:0]  tmp;
        bit           e_rv;
        bit           e_done;
        bit           hs_a;
        bit           hs_w;
        int           t;

        t = cyc - 5;
        e_rv = (t >= 0) && (t >= kill_cyc) && tag0[idx(t)];
        e_res = e_rv ? mat_vec(vec0[idx(t)]) : '0;
        e_done = e_rv && (phase == P_DRAIN) && (rcnt + 1 == NV);
        e_ad = '0;
        for (int r = 0; r < 4; r++) begin
            tmp = vec_at(cyc - r);
            e_ad[8*r +: 8] = tmp[8*r +: 8];
        end

        chk("busy", busy, phase != P_IDLE);
        chk("wt_ready", wt_ready, phase == P_LOAD);
        chk("act_ready", act_ready, phase == P_STREAM);
        chk("arr_control", arr_control, phase == P_LOAD);
        chk("arr_wt", arr_wt, exp_wt);
        chk("arr_data", arr_data, e_ad);
        chk("res_valid", res_valid, e_rv);
        chk("done", done, e_done);
        if (e_rv) chk("res_data", res_data, e_res);

        if (res_valid) begin
            beats++;
            res_log.push_back(res_data);
            if (first_res < 0) first_res = cyc;
        end
        if (done) done_beats = beats;
        if (act_valid && act_ready && first_acc < 0) first_acc = cyc;

        if (rst) begin
            phase = P_IDLE;
            kill_cyc = cyc + 1;
            wcnt = 0;
            vcnt = 0;
            rcnt = 0;
            exp_wt = '0;
            vec0[idx(cyc + 1)] = '0;
            tag0[idx(cyc + 1)] = 1'b0;
        end else begin
            hs_a = act_valid && (phase == P_STREAM);
            hs_w = wt_valid && (phase == P_LOAD);
            vec0[idx(cyc + 1)] = hs_a ? act_data : '0;
            tag0[idx(cyc + 1)] = hs_a;
            if (e_rv) rcnt++;
            case (phase)
                P_IDLE: if (start) begin
                    phase = P_LOAD;
                    wcnt = 0;
                    vcnt = 0;
                    rcnt = 0;
                end
                P_LOAD: if (hs_w) begin
                    w_rows[wcnt] = wt_data;
                    exp_wt = wt_data;
                    wcnt++;
                    if (wcnt == 4) phase = P_STREAM;
                end
                P_STREAM: if (hs_a) begin
                    vcnt++;
                    if (vcnt == NV) phase = P_DRAIN;
                end
                default: if (e_done) phase = P_IDLE;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    bit [31:0] wts [4];
    bit [31:0] vecs [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic load_wts(input int gap, input bit rand_gap);
        int g;
        int ng;
        for (int r = 0; r < 4; r++) begin
            wt_valid = 1'b1;
            wt_data = wts[r];
            g = 0;
            while (!wt_ready && g < 50) begin
                step();
                g++;
            end
            if (!wt_ready) begin
                timeout_fail("wt_ready_wait");
                wt_valid = 1'b0;
                return;
            end
            step();
            wt_valid = 1'b0;
            wt_data = $urandom;
            chk("arr_wt_row", arr_wt, wts[r]);
            ng = rand_gap ? int'($urandom_range(0, 2)) : gap;
            for (int s = 0; s < ng && r < 3; s++) begin
                chk("arr_control_stall", arr_control, 1'b1);
                step();
            end
        end
        chk("stream_entry_ctl", arr_control, 1'b0);
        chk("stream_entry_ready", act_ready, 1'b1);
    endtask

    // mode 0: back-to-back, 1: one bubble after each vector, 2: random bubbles
    task automatic send_vecs(input int mode, input int count);
        int g;
        int nb;
        for (int k = 0; k < count; k++) begin
            act_valid = 1'b1;
            act_data = vecs[k];
            g = 0;
            while (!act_ready && g < 50) begin
                step();
                g++;
            end
            if (!act_ready) begin
                timeout_fail("act_ready_wait");
                act_valid = 1'b0;
                return;
            end
            step();
            act_valid = 1'b0;
            act_data = $urandom;
            nb = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
            repeat (nb) step();
        end
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 200) begin
            step();
            g++;
        end
        if (!done) begin
            timeout_fail("done_wait");
        end else begin
            chk("done_with_res_valid", res_valid, 1'b1);
            step();
            chk("busy_after_done", busy, 1'b0);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ctl_flags"}, {busy, done, res_valid, wt_ready, act_ready, arr_control}, 6'b0);
        chk({tag, "_arr_wt"}, arr_wt, 32'h0);
        chk({tag, "_arr_data"}, arr_data, 32'h0);
        chk({tag, "_res_data"}, res_data, 128'h0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        wt_valid = 1'b0;
        wt_data = '0;
        act_valid = 1'b0;
        act_data = '0;
        repeat (3) step();
        check_quiet("reset");
        rst = 1'b0;
        step();

        // Identity weights with stalls, back-to-back vectors.
        wts[0] = 32'h0000_0001;
        wts[1] = 32'h0000_0100;
        wts[2] = 32'h0001_0000;
        wts[3] = 32'h0100_0000;
        for (int k = 0; k < 4; k++) begin
            vecs[k] = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
        end
        clear_obs();
        do_start();
        chk("load_ctl_first", arr_control, 1'b1);
        load_wts(2, 1'b0);
        send_vecs(0, 4);
        wait_done();
        chk("ident_beats", beats, 4);
        chk("ident_latency", first_res - first_acc, 6);
        chk("ident_done_beat", done_beats, 4);
        if (res_log.size() == 4) begin
            chk("ident_res0", res_log[0], {32'd4, 32'd3, 32'd2, 32'd1});
            chk("ident_res1", res_log[1], {32'd8, 32'd7, 32'd6, 32'd5});
            chk("ident_res2", res_log[2], {32'd12, 32'd11, 32'd10, 32'd9});
            chk("ident_res3", res_log[3], {32'd16, 32'd15, 32'd14, 32'd13});
        end

        // Random tile, toggling valid, start held high during STREAM.
        for (int k = 0; k < 4; k++) begin
            wts[k] = $urandom;
            vecs[k] = $urandom;
        end
        clear_obs();
        do_start();
        load_wts(0, 1'b0);
        start = 1'b1;
        send_vecs(1, 4);
        start = 1'b0;
        wait_done();
        chk("bubble_beats", beats, 4);
        chk("bubble_done_beat", done_beats, 4);

        // Reset after two vectors, then full-scale job.
        for (int k = 0; k < 4; k++) begin
            wts[k] = $urandom;
            vecs[k] = $urandom;
        end
        do_start();
        load_wts(0, 1'b0);
        send_vecs(0, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_quiet("midrst");
        clear_obs();
        repeat (10) step();
        chk("midrst_no_res", beats, 0);

        for (int k = 0; k < 4; k++) begin
            wts[k] = 32'hFFFF_FFFF;
            vecs[k] = 32'hFFFF_FFFF;
        end
        clear_obs();
        do_start();
        load_wts(1, 1'b0);
        send_vecs(0, 4);
        wait_done();
        chk("full_beats", beats, 4);
        if (res_log.size() == 4) begin
            for (int c = 0; c < 4; c++) begin
                chk("full_lane", res_log[3][32*c +: 32], 32'd260100);
            end
        end

        // Random jobs with random stalls and bubbles.
        for (int j = 0; j < 6; j++) begin
            for (int k = 0; k < 4; k++) begin
                wts[k] = $urandom;
                vecs[k] = $urandom;
            end
            clear_obs();
            repeat ($urandom_range(0, 3)) step();
            do_start();
            load_wts(0, 1'b1);
            send_vecs(2, 4);
            wait_done();
            chk("rand_beats", beats, 4);
        end

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
